imem_fill_responder: RTL and testbench
======================================

// Module: imem_fill_responder
// PURPOSE
// - Responder side of the instruction-cache line-fill interface: accepts one line-fill request at a time and returns the line as big-endian beats.
// - Sits behind instructionCache as its backing instruction memory, with an internal beat-wide array.
// - A loader port writes the array with little-endian words; the block stores them byte-swapped so fills come out big-endian.
// PARAMETERS
// - LINEBYTES   64    bytes per cache line; power of 2, >= BEATBYTES
// - BEATBYTES   8     bytes per response beat; power of 2
// - MEMWORDS    4096  array depth in beats; multiple of LINEBYTES/BEATBYTES
// - READLATENCY 2     idle cycles between request accept and first beat; >= 0
// - derived: BEATS = LINEBYTES/BEATBYTES; LOFF = log2(LINEBYTES)
// PORTS
// - clk        in   1             rising-edge clock
// - reset      in   1             synchronous reset, active-high
// - req_valid  in   1             fill request valid
// - req_ready  out  1             responder can accept a request
// - req_addr   in   56            byte address in line; bits [LOFF-1:0] ignored
// - rsp_valid  out  1             response beat valid
// - rsp_ready  in   1             consumer accepts beat
// - rsp_data   out  BEATBYTES*8   beat data, big-endian (lowest address byte in MSBs)
// - rsp_last   out  1             final beat of the line
// - rsp_error  out  1             line out of range; rsp_data is 0
// - load_en    in   1             write one beat into the array
// - load_ready out  1             load write is accepted this cycle
// - load_addr  in   log2(MEMWORDS) beat index
// - load_data  in   BEATBYTES*8   little-endian beat (byte 0 in [7:0])
// BEHAVIOUR
// - Reset: state IDLE, req_ready=1, load_ready=1, rsp_valid=0, rsp_last=0, rsp_error=0, rsp_data=0, beat counter=0, wait counter=0.
//   Array contents are not reset.
// - Reset mid-operation abandons the line; no further beats. req_ready=1 in the cycle after reset deasserts.
// - States: IDLE, WAIT, SEND.
//   - IDLE:
//     - req_ready=load_ready=1; all other outputs 0.
//     - req_valid&&req_ready at edge T: latch line = req_addr[55:LOFF]; set error when line*BEATS >= MEMWORDS.
//     - Next state WAIT, or SEND when READLATENCY=0.
//   - WAIT: count READLATENCY cycles, then SEND. req_ready=0, load_ready=0.
//   - SEND:
//     - First beat has rsp_valid=1 at cycle T+1+READLATENCY.
//     - Beat k = array[line*BEATS+k], k = 0..BEATS-1.
//     - rsp_last=1 only on k=BEATS-1.
//   - rsp_error is constant for all beats of an erroring line; such a line still sends BEATS beats with data 0.
// - Handshake:
//   - A beat transfers on rsp_valid&&rsp_ready.
//   - While rsp_valid&&!rsp_ready, rsp_data, rsp_last and rsp_error hold stable.
//   - After a transfer the next beat is valid in the following cycle, with no bubble; rsp_ready held high gives BEATS consecutive beats.
//   - rsp_valid never drops before its beat transfers.
// - Completion:
//   - Last beat transfers at edge E: state IDLE after E, req_ready=1 in cycle E+1.
//   - A request is never accepted in the same cycle as a last beat.
// - Loader:
//   - Write occurs on load_en&&load_ready.
//   - Stored word is the byte-reverse of load_data: byte i of load_data becomes byte i from the MSB.
//   - load_en outside IDLE is ignored, because load_ready=0 there.
//   - A simultaneous req accept and load write in IDLE are both performed. The write lands before the WAIT/SEND read, so the fill returns the new data.
// - Widths: line*BEATS+k is computed at 56+ bits before the range compare, so a huge address never wraps into range.
// TESTING
// - Reset, then load beats 0..7 with 64'h0706050403020100+k; req_addr=56'h0.
//   -> first rsp_valid 3 cycles after accept; beat0 = 64'h0001020304050607; rsp_last only on beat7.
// - req_addr=56'h7F with beats 8..15 loaded (LINEBYTES=64) -> offset ignored; line 1 returned, i.e. beats 8..15 in order.
// - rsp_ready toggled 1,0,0,1,... during SEND -> each beat held stable while stalled, and no beat dropped or duplicated.
// - req_addr=56'h1_0000 with MEMWORDS=4096 -> 8 beats, each rsp_data=0 and rsp_error=1; rsp_last on beat 7.
// - Assert reset while beat 3 is pending -> rsp_valid=0 the next cycle; req_ready=1 after reset deasserts; a new request completes normally.
// - req_valid held high continuously -> two lines back-to-back, with exactly one idle cycle (req_ready=1) between last beat and next accept; load_en during SEND ignored.

Source files
------------

// File: rtl/imem_fill_responder.sv
// Instruction-memory line-fill responder: accepts one line request at a time and
// returns the line as big-endian beats from an internal byte-swapped array.
module imem_fill_responder #(
    parameter int LINEBYTES   = 64,
    parameter int BEATBYTES   = 8,
    parameter int MEMWORDS    = 4096,
    parameter int READLATENCY = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [55:0]                   req_addr,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [BEATBYTES*8-1:0]        rsp_data,
    output logic                          rsp_last,
    output logic                          rsp_error,
    input  logic                          load_en,
    output logic                          load_ready,
    input  logic [$clog2(MEMWORDS)-1:0]   load_addr,
    input  logic [BEATBYTES*8-1:0]        load_data
);

    localparam int BEATS = LINEBYTES / BEATBYTES;
    localparam int LOFF  = $clog2(LINEBYTES);
    localparam int AW    = $clog2(MEMWORDS);
    localparam int DW    = BEATBYTES * 8;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WW    = (READLATENCY > 1) ? $clog2(READLATENCY) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [WW-1:0] WAIT_LAST = (READLATENCY > 0) ? WW'(READLATENCY - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic            err_q, err_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [WW-1:0]   wait_q, wait_d;

    logic [DW-1:0]   mem [MEMWORDS];
    logic [63:0]     line_base;
    logic [AW-1:0]   rd_idx;
    logic [DW-1:0]   load_swapped;
    logic            unused_bits;

    // Range check runs on the full-width beat index so huge addresses cannot alias into the array.
    always_comb begin
        line_base = 64'(req_addr[55:LOFF]) * 64'(BEATS);
        rd_idx    = base_q + AW'(beat_q);
    end

    assign unused_bits = ^{req_addr[LOFF-1:0], line_base[63:AW]};

    always_comb begin
        load_swapped = '0;
        for (int unsigned i = 0; i < BEATBYTES; i++) begin
            load_swapped[8*(BEATBYTES-1-i) +: 8] = load_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            err_q   <= 1'b0;
            beat_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            err_q   <= err_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        err_d   = err_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    base_d  = line_base[AW-1:0];
                    err_d   = line_base >= 64'(MEMWORDS);
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = (READLATENCY == 0) ? SEND : WAIT;
                end
            end
            WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = SEND;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            SEND: begin
                if (rsp_ready) begin
                    if (beat_q == BEAT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        load_ready = 1'b0;
        rsp_valid  = 1'b0;
        rsp_last   = 1'b0;
        rsp_error  = 1'b0;
        rsp_data   = '0;
        case (state_q)
            IDLE: begin
                req_ready  = 1'b1;
                load_ready = 1'b1;
            end
            SEND: begin
                rsp_valid = 1'b1;
                rsp_last  = (beat_q == BEAT_LAST);
                rsp_error = err_q;
                rsp_data  = err_q ? '0 : mem[rd_idx];
            end
            default: ;
        endcase
    end

    // Loads only happen in IDLE, so the array is stable for the whole fill.
    always_ff @(posedge clk) begin
        if (load_en && load_ready) begin
            mem[load_addr] <= load_swapped;
        end
    end

endmodule

// File: tb/tb_imem_fill_responder.sv
// Scoreboard bench for imem_fill_responder: expected beats are queued at request
// accept from a byte-swapped memory model and checked as the DUT emits them.
module tb_imem_fill_responder;

    localparam int RL = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [55:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_last;
    logic        rsp_error;
    logic        load_en;
    logic        load_ready;
    logic [11:0] load_addr;
    logic [63:0] load_data;

    imem_fill_responder #(
        .LINEBYTES  (64),
        .BEATBYTES  (8),
        .MEMWORDS   (4096),
        .READLATENCY(RL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_error (rsp_error),
        .load_en   (load_en),
        .load_ready(load_ready),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        err;
    } beat_t;

    beat_t       sb[$];
    logic [63:0] model [4096];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          acc_edge = 0;
    int          last_edge = 0;
    int          lines_done = 0;
    int          beat_idx = 0;
    bit          first_pend = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [11:0] a, input logic [63:0] d);
        model[a] = {<<8{d}};
    endtask

    // Accepts and beats are observed at the falling edge, half a cycle before they take effect.
    always @(negedge clk) begin
        if (!reset) begin
            if (req_valid && req_ready) begin
                logic [63:0] line;
                logic [63:0] base;
                bit          err;
                beat_t       e;
                line = {8'b0, req_addr} >> 6;
                base = line * 64'd8;
                err  = base >= 64'd4096;
                for (int k = 0; k < 8; k++) begin
                    e.data = err ? 64'd0 : model[base[11:0] + 12'(k)];
                    e.last = (k == 7);
                    e.err  = err;
                    sb.push_back(e);
                end
                acc_edge   = cyc;
                first_pend = 1;
                beat_idx   = 0;
            end
            if (rsp_valid) begin
                if (first_pend) begin
                    check("latency", 64'(cyc - acc_edge), 64'(RL + 1));
                    first_pend = 0;
                end
                if (sb.size() == 0) begin
                    check("sb_empty", {63'b0, rsp_valid}, 64'd0);
                end else begin
                    check("rsp_data", rsp_data, sb[0].data);
                    check("rsp_last", {63'b0, rsp_last}, {63'b0, sb[0].last});
                    check("rsp_error", {63'b0, rsp_error}, {63'b0, sb[0].err});
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        beat_idx++;
                        if (rsp_last) begin
                            lines_done++;
                            last_edge = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic do_load(input logic [11:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = a; load_data = d;
        model_write(a, d);
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic do_req(input logic [55:0] a, input bit with_load,
                          input logic [11:0] la, input logic [63:0] ld);
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a;
        if (with_load) begin
            load_en = 1'b1; load_addr = la; load_data = ld;
            model_write(la, ld);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; load_en = 1'b0;
    endtask

    task automatic wait_lines(input int target, input bit stall);
        int ph = 0;
        for (int t = 0; t < 300 && lines_done < target; t++) begin
            @(posedge clk); #1;
            rsp_ready = stall ? (ph % 3 == 0) : 1'b1;
            ph++;
        end
        check("lines_done", 64'(lines_done), 64'(target));
        rsp_ready = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {63'b0, req_ready}, 64'd1);
        check("rst_load_ready", {63'b0, load_ready}, 64'd1);
        check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("rst_rsp_last", {63'b0, rsp_last}, 64'd0);
        check("rst_rsp_error", {63'b0, rsp_error}, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        reset = 1'b0;

        for (int k = 0; k < 24; k++) do_load(12'(k), 64'h0706050403020100 + 64'(k));
        for (int k = 4088; k < 4096; k++) do_load(12'(k), {$urandom, $urandom});
        check("swap_beat0", model[0], 64'h0001020304050607);

        do_req(56'h0, 0, '0, '0);              wait_lines(1, 0);
        do_req(56'h7F, 0, '0, '0);             wait_lines(2, 0);
        do_req(56'h40, 0, '0, '0);             wait_lines(3, 1);
        do_req(56'h1_0000, 0, '0, '0);         wait_lines(4, 0);
        do_req(56'h7FC0, 0, '0, '0);           wait_lines(5, 0);
        do_req(56'h8000, 0, '0, '0);           wait_lines(6, 0);
        do_req(56'hFF_FFFF_FFFF_FFC0, 0, '0, '0); wait_lines(7, 0);
        do_req(56'h80, 1, 12'd16, 64'hDEAD_BEEF_0BAD_F00D); wait_lines(8, 0);

        do_req(56'h0, 0, '0, '0);
        for (int t = 0; t < 50; t++) begin
            if (beat_idx == 3) begin
                rsp_ready = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        check("beat3_pending", {63'b0, rsp_valid}, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", {63'b0, rsp_valid}, 64'd0);
        sb.delete();
        first_pend = 0;
        reset = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", {63'b0, req_ready}, 64'd1);
        do_req(56'h40, 0, '0, '0);             wait_lines(9, 0);

        req_valid = 1'b1; req_addr = 56'h0;
        for (int t = 0; t < 20 && !rsp_valid; t++) begin
            @(posedge clk); #1;
        end
        load_en = 1'b1; load_addr = 12'd8; load_data = 64'hFFFF_0000_FFFF_0000;
        req_addr = 56'h40;
        @(posedge clk); #1;
        load_en = 1'b0;
        wait_lines(10, 0);
        for (int t = 0; t < 10 && !first_pend; t++) @(negedge clk);
        check("b2b_gap", 64'(acc_edge - last_edge), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_lines(11, 0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_left", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
